// File: rtl/fp_mul_norm_round_if.sv
// Handshake and data bundle between the FP32 mantissa multiplier core and
// the normalize/round back-end, plus the back-end's result channel.
interface fp_mul_norm_round_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_sign;
  logic [EXP_W:0]             in_exp_sum;
  logic [2*(MAN_W+1)-1:0]     in_mant_prod;
  logic                       in_nan;
  logic                       in_inf;
  logic                       in_zero;
  logic                       out_valid;
  logic                       out_ready;
  logic [EXP_W+MAN_W:0]       c;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output in_valid, in_sign, in_exp_sum, in_mant_prod, in_nan, in_inf, in_zero,
    output out_ready,
    input  in_ready, out_valid, c, overflow, underflow
  );

  modport slave (
    input  in_valid, in_sign, in_exp_sum, in_mant_prod, in_nan, in_inf, in_zero,
    input  out_ready,
    output in_ready, out_valid, c, overflow, underflow
  );
endinterface

// File: rtl/fp_mul_norm_round.sv
// FP32 multiplier back-end: normalize the raw significand product (stage 1),
// then round-to-nearest-even, range-check and pack (stage 2), valid/ready pipelined.
module fp_mul_norm_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_mul_norm_round_if.slave   bus
);

  localparam int PW  = 2 * (MAN_W + 1);
  localparam int EW  = EXP_W + 3;
  localparam int CW  = 1 + EXP_W + MAN_W;
  localparam int LOW = PW - 2 - MAN_W;
  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO  = '0;

  logic                  v1_reg, v2_reg, adv2;
  logic                  s1_sign_reg, s1_guard_reg, s1_sticky_reg;
  logic [MAN_W-1:0]      s1_frac_reg;
  logic signed [EW-1:0]  s1_exp_reg;
  logic                  s1_nan_reg, s1_inf_reg, s1_zero_reg;
  logic [CW-1:0]         c_reg;
  logic                  ovf_reg, unf_reg;

  logic                  top;
  logic [MAN_W-1:0]      frac_next;
  logic                  guard_next, sticky_next;
  logic signed [EW-1:0]  exp_next;

  logic                  round_up, carry;
  logic [MAN_W-1:0]      frac_rnd;
  logic signed [EW-1:0]  exp_rnd;
  logic [CW-1:0]         c_next;
  logic                  ovf_next, unf_next;

  assign adv2          = !v2_reg || bus.out_ready;
  assign bus.in_ready  = !v1_reg || adv2;
  assign bus.out_valid = v2_reg;
  assign bus.c         = c_reg;
  assign bus.overflow  = ovf_reg;
  assign bus.underflow = unf_reg;

  // Product of two [1,2) significands lies in [1,4): bit PW-1 says which.
  assign top = bus.in_mant_prod[PW-1];

  always_comb begin
    frac_next   = top ? bus.in_mant_prod[PW-2 -: MAN_W] : bus.in_mant_prod[PW-3 -: MAN_W];
    guard_next  = top ? bus.in_mant_prod[LOW] : bus.in_mant_prod[LOW-1];
    sticky_next = top ? |bus.in_mant_prod[LOW-1:0] : |bus.in_mant_prod[LOW-2:0];
    exp_next    = $signed({2'b00, bus.in_exp_sum}) - BIAS_S + $signed({{(EW-1){1'b0}}, top});
  end

  always_comb begin
    round_up          = s1_guard_reg & (s1_sticky_reg | s1_frac_reg[0]);
    {carry, frac_rnd} = {1'b0, s1_frac_reg} + {{MAN_W{1'b0}}, round_up};
    exp_rnd           = s1_exp_reg + $signed({{(EW-1){1'b0}}, carry});
    c_next            = {s1_sign_reg, exp_rnd[EXP_W-1:0], frac_rnd};
    ovf_next          = 1'b0;
    unf_next          = 1'b0;
    if (s1_nan_reg) begin
      c_next = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (s1_inf_reg) begin
      c_next = {s1_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s1_zero_reg) begin
      c_next = {s1_sign_reg, {(EXP_W+MAN_W){1'b0}}};
    end else if (exp_rnd >= EMAX) begin
      c_next   = {s1_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_next = 1'b1;
    end else if (exp_rnd <= EZERO) begin
      // Flush-to-zero, judged on the exponent after any rounding carry.
      c_next   = {s1_sign_reg, {(EXP_W+MAN_W){1'b0}}};
      unf_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_reg        <= 1'b0;
      v2_reg        <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_frac_reg   <= '0;
      s1_guard_reg  <= 1'b0;
      s1_sticky_reg <= 1'b0;
      s1_exp_reg    <= '0;
      s1_nan_reg    <= 1'b0;
      s1_inf_reg    <= 1'b0;
      s1_zero_reg   <= 1'b0;
      c_reg         <= '0;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
    end else begin
      if (bus.in_ready) begin
        v1_reg <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sign_reg   <= bus.in_sign;
          s1_frac_reg   <= frac_next;
          s1_guard_reg  <= guard_next;
          s1_sticky_reg <= sticky_next;
          s1_exp_reg    <= exp_next;
          s1_nan_reg    <= bus.in_nan;
          s1_inf_reg    <= bus.in_inf;
          s1_zero_reg   <= bus.in_zero;
        end
      end
      // Output registers only move when stage 2 may advance, so they hold under backpressure.
      if (adv2) begin
        v2_reg <= v1_reg;
        if (v1_reg) begin
          c_reg   <= c_next;
          ovf_reg <= ovf_next;
          unf_reg <= unf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Self-checking bench for fp_mul_norm_round: directed cases plus randomized
// traffic under random backpressure, scored against an arithmetic reference model.
module tb_fp_mul_norm_round;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  typedef logic [33:0] res_t;   // {c, overflow, underflow}
  res_t sb[$];
  res_t sb_exp;

  fp_mul_norm_round_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_mul_norm_round #(.EXP_W(8), .MAN_W(23), .BIAS(127)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Value-level rounding: keep the integer significand, compare the discarded remainder to one half.
  function automatic res_t model(input bit s, input int es, input logic [47:0] p,
                                 input bit nan, input bit inf, input bit zero);
    longint unsigned prod, q, rem, half;
    int sh, e;
    if (nan)  return {32'h7FC00000, 2'b00};
    if (inf)  return {s, 8'hFF, 23'h0, 2'b00};
    if (zero) return {s, 31'h0, 2'b00};
    prod = 64'(p);
    sh   = p[47] ? 24 : 23;
    q    = prod >> sh;
    rem  = prod - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    e = es - 127 + (sh - 23);
    if (q >= (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0, 2'b10};
    if (e <= 0)   return {s, 31'h0, 2'b01};
    return {s, e[7:0], q[22:0], 2'b00};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_spurious_output", 64'd1, 64'd0);
        end else begin
          sb_exp = sb.pop_front();
          check("sb_result", 64'({bus.c, bus.overflow, bus.underflow}), 64'(sb_exp));
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(bus.in_sign, int'(bus.in_exp_sum), bus.in_mant_prod,
                           bus.in_nan, bus.in_inf, bus.in_zero));
    end
  end

  task automatic set_in(input bit s, input int es, input logic [47:0] p,
                        input bit nan, input bit inf, input bit zero);
    bus.in_sign      = s;
    bus.in_exp_sum   = 9'(es);
    bus.in_mant_prod = p;
    bus.in_nan       = nan;
    bus.in_inf       = inf;
    bus.in_zero      = zero;
  endtask

  task automatic rand_in();
    logic [23:0] ma, mb;
    int r, es, f;
    ma = {1'b1, 23'($urandom)};
    r  = $urandom_range(0, 5);
    if (r == 0)      mb = 24'h800000;
    else if (r == 1) mb = 24'hC00000;
    else             mb = {1'b1, 23'($urandom)};
    r = $urandom_range(0, 9);
    if (r == 0)      es = $urandom_range(0, 508);
    else if (r == 1) es = $urandom_range(120, 130);
    else if (r == 2) es = $urandom_range(375, 385);
    else             es = $urandom_range(200, 300);
    f = $urandom_range(0, 19);
    set_in(1'($urandom), es, 48'(ma) * 48'(mb), f == 0, f == 1, f == 2);
  endtask

  task automatic wait_accept(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.in_ready && k < 50);
    if (!bus.in_ready) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input bit s, input int es, input logic [47:0] p,
                         input bit nan, input bit inf, input bit zero,
                         input logic [31:0] ec, input bit eo, input bit eu);
    int k = 0;
    @(posedge clk);
    #1;
    set_in(s, es, p, nan, inf, zero);
    bus.in_valid = 1'b1;
    wait_accept(tag);
    do begin
      @(negedge clk);
      k++;
    end while (!bus.out_valid && k < 20);
    if (!bus.out_valid) begin
      check({tag, "_out_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_c"}, 64'(bus.c), 64'(ec));
      check({tag, "_ovf"}, 64'(bus.overflow), 64'(eo));
      check({tag, "_unf"}, 64'(bus.underflow), 64'(eu));
    end
    $display("txn %s: s=%0d exp_sum=%0d prod=%h -> c=%h ovf=%0d unf=%0d",
             tag, s, es, p, bus.c, bus.overflow, bus.underflow);
  endtask

  logic [31:0] bp_exp [4];
  logic [31:0] got    [4];
  int          idx, n_got;
  bit          acc_now;

  initial begin
    bp_exp[0] = 32'h00800000;
    bp_exp[1] = 32'h01000000;
    bp_exp[2] = 32'h01800000;
    bp_exp[3] = 32'h02000000;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_in(0, 0, 48'h0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_c", 64'(bus.c), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    check("rst_unf", 64'(bus.underflow), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;

    // Latency: out_valid exactly two cycles after the input transfer
    @(posedge clk);
    #1;
    set_in(1, 254, 48'h400000000000, 0, 0, 0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("lat_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
    check("lat_c", 64'(bus.c), 64'h00000000BF800000);
    check("lat_flags", 64'({bus.overflow, bus.underflow}), 64'd0);
    $display("txn latency: c=%h", bus.c);
    @(negedge clk);
    check("lat_drained", 64'(bus.out_valid), 64'd0);

    // Directed rounding, range and special cases
    run_one("round_carry", 0, 254, 48'hFFFFFF800000, 0, 0, 0, 32'h40800000, 0, 0);
    run_one("tie_even",    0, 254, 48'h800000800000, 0, 0, 0, 32'h40000000, 0, 0);
    run_one("overflow",    0, 508, 48'h400000000000, 0, 0, 0, 32'h7F800000, 1, 0);
    run_one("underflow",   1, 3,   48'h400000000000, 0, 0, 0, 32'h80000000, 0, 1);
    run_one("e_max_norm",  0, 381, 48'h400000000000, 0, 0, 0, 32'h7F000000, 0, 0);
    run_one("e_255",       1, 382, 48'h400000000000, 0, 0, 0, 32'hFF800000, 1, 0);
    run_one("e_zero",      0, 127, 48'h400000000000, 0, 0, 0, 32'h00000000, 0, 1);
    run_one("round_to_min",0, 127, 48'h7FFFFFC00000, 0, 0, 0, 32'h00800000, 0, 0);
    run_one("nan",         1, 254, 48'h400000000000, 1, 0, 0, 32'h7FC00000, 0, 0);
    run_one("inf",         1, 254, 48'h400000000000, 0, 1, 0, 32'hFF800000, 0, 0);
    run_one("zero",        0, 254, 48'h400000000000, 0, 0, 1, 32'h00000000, 0, 0);

    // Backpressure: only two accepted while out_ready is low, output held
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    idx = 0;
    set_in(0, 128, 48'h400000000000, 0, 0, 0);
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      acc_now = bus.in_valid && bus.in_ready;
      if (cyc >= 2) begin
        check("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
        check("bp_c_held", 64'(bus.c), 64'(bp_exp[0]));
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        idx++;
        if (idx < 4) set_in(0, 128 + idx, 48'h400000000000, 0, 0, 0);
        else bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    n_got = 0;
    for (int cyc = 0; cyc < 20 && n_got < 4; cyc++) begin
      @(negedge clk);
      acc_now = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        got[n_got] = bus.c;
        $display("txn bp_out[%0d]: c=%h", n_got, bus.c);
        n_got++;
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        idx++;
        if (idx < 4) set_in(0, 128 + idx, 48'h400000000000, 0, 0, 0);
        else bus.in_valid = 1'b0;
      end
    end
    check("bp_count", 64'(n_got), 64'd4);
    for (int i = 0; i < 4; i++) check("bp_order", 64'(got[i]), 64'(bp_exp[i]));
    repeat (2) begin
      @(negedge clk);
      check("bp_no_dup", 64'(bus.out_valid), 64'd0);
    end

    // Randomized traffic with random backpressure, checked by the scoreboard
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      acc_now = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (!bus.in_valid || acc_now) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        rand_in();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && (bus.in_valid || sb.size() != 0); cyc++) begin
      @(negedge clk);
      acc_now = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc_now) bus.in_valid = 1'b0;
    end
    check("rand_drain_in_valid", 64'(bus.in_valid), 64'd0);
    check("rand_drain_empty", 64'(sb.size()), 64'd0);
    $display("txn random: drained, scoreboard checks so far %0d", n_total);

    // Async reset with both stages full
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    set_in(0, 200, 48'h400000000000, 0, 0, 0);
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    #1;
    check("arst_pre_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_c", 64'(bus.c), 64'd0);
    check("arst_flags", 64'({bus.overflow, bus.underflow}), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("arst_no_output", 64'(bus.out_valid), 64'd0);
    end
    run_one("post_reset", 0, 254, 48'h400000000000, 0, 0, 0, 32'h3F800000, 0, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
